// File: rtl/mem_1rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_1rw_arbiter
// Purpose : Two-requester arbiter in front of a single-port (1RW) memory.
//           Round-robin between p0 and p1, with an optional grant lock.
//           Read data comes back on the requester's rdata/rvalid one cycle
//           after its read is accepted.
// Config  : MEM_1RW_ARBITER_LOCK_EN - when defined, pn_lock_i keeps the
//           grant on port n until it issues a request with lock low.
//           When undefined, pn_lock_i is ignored.
// Ports   : clk_i, reset_i (async, active-high)
//           pn_v_i/w_i/lock_i/addr_i/data_i  : requests, n in {0,1}
//           pn_ready_o                        : request accepted this cycle
//           pn_rvalid_o/rdata_o               : read response
//           mem_v_o/w_o/addr_o/data_o         : memory command
//           mem_data_i                        : memory read data (1 cycle)
// Rev     : 1.0 - initial release
// ============================================================================
module mem_1rw_arbiter #(
   parameter int WIDTH_P = 4,
   parameter int ADDR_P  = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               p0_v_i,
   input  logic               p0_w_i,
   input  logic               p0_lock_i,
   input  logic [ADDR_P-1:0]  p0_addr_i,
   input  logic [WIDTH_P-1:0] p0_data_i,
   output logic               p0_ready_o,
   output logic               p0_rvalid_o,
   output logic [WIDTH_P-1:0] p0_rdata_o,
   input  logic               p1_v_i,
   input  logic               p1_w_i,
   input  logic               p1_lock_i,
   input  logic [ADDR_P-1:0]  p1_addr_i,
   input  logic [WIDTH_P-1:0] p1_data_i,
   output logic               p1_ready_o,
   output logic               p1_rvalid_o,
   output logic [WIDTH_P-1:0] p1_rdata_o,
   output logic               mem_v_o,
   output logic               mem_w_o,
   output logic [ADDR_P-1:0]  mem_addr_o,
   output logic [WIDTH_P-1:0] mem_data_o,
   input  logic [WIDTH_P-1:0] mem_data_i
);

   // last_q: most recently granted port (1 = p1). Reset to 1 so p0 wins
   // the first contention.
   logic       last_q, last_d;
   logic [1:0] rvalid_q, rvalid_d;
   logic       rr0, rr1;
   logic       grant0, grant1;

`ifdef MEM_1RW_ARBITER_LOCK_EN
   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCK0    = 2'd1,
      LOCK1    = 2'd2
   } lock_state_e;

   lock_state_e lock_q, lock_d;
`else
   logic unused_lock;
   assign unused_lock = p0_lock_i ^ p1_lock_i;
`endif

   // Round-robin choice: under contention the port that did not win last.
   always_comb begin
      rr0 = p0_v_i;
      rr1 = p1_v_i;
      if (p0_v_i && p1_v_i) begin
         rr0 = last_q;
         rr1 = ~last_q;
      end
   end

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!reset_i) begin
`ifdef MEM_1RW_ARBITER_LOCK_EN
         // A locked owner excludes the other port even while it is idle.
         case (lock_q)
            LOCK0:   grant0 = p0_v_i;
            LOCK1:   grant1 = p1_v_i;
            default: begin
               grant0 = rr0;
               grant1 = rr1;
            end
         endcase
`else
         grant0 = rr0;
         grant1 = rr1;
`endif
      end
   end

   always_comb begin
      last_d   = last_q;
      rvalid_d = {grant1 & ~p1_w_i, grant0 & ~p0_w_i};
      if (grant0) begin
         last_d = 1'b0;
      end else if (grant1) begin
         last_d = 1'b1;
      end
`ifdef MEM_1RW_ARBITER_LOCK_EN
      lock_d = lock_q;
      if (grant0) begin
         lock_d = p0_lock_i ? LOCK0 : UNLOCKED;
      end else if (grant1) begin
         lock_d = p1_lock_i ? LOCK1 : UNLOCKED;
      end
`endif
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         last_q   <= 1'b1;
         rvalid_q <= 2'b00;
`ifdef MEM_1RW_ARBITER_LOCK_EN
         lock_q   <= UNLOCKED;
`endif
      end else begin
         last_q   <= last_d;
         rvalid_q <= rvalid_d;
`ifdef MEM_1RW_ARBITER_LOCK_EN
         lock_q   <= lock_d;
`endif
      end
   end

   assign p0_ready_o = grant0;
   assign p1_ready_o = grant1;

   // Memory command is a plain mux of the granted port; zero when idle.
   always_comb begin
      mem_v_o    = grant0 | grant1;
      mem_w_o    = 1'b0;
      mem_addr_o = '0;
      mem_data_o = '0;
      if (grant0) begin
         mem_w_o    = p0_w_i;
         mem_addr_o = p0_addr_i;
         mem_data_o = p0_data_i;
      end else if (grant1) begin
         mem_w_o    = p1_w_i;
         mem_addr_o = p1_addr_i;
         mem_data_o = p1_data_i;
      end
   end

   assign p0_rvalid_o = rvalid_q[0];
   assign p1_rvalid_o = rvalid_q[1];
   assign p0_rdata_o  = rvalid_q[0] ? mem_data_i : '0;
   assign p1_rdata_o  = rvalid_q[1] ? mem_data_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_1rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_1rw_arbiter
// Purpose : Self-checking bench for mem_1rw_arbiter. A behavioural model
//           (grant owner, last winner, pending reads, shadow memory) is
//           compared against the DUT on every negative clock edge; directed
//           sequences add literal expectations; random traffic follows.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_mem_1rw_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       v0 = 0, w0 = 0, l0 = 0, v1 = 0, w1 = 0, l1 = 0;
   logic [3:0] a0 = 0, d0 = 0, a1 = 0, d1 = 0;
   logic       rdy0, rdy1, rv0, rv1, mv, mw;
   logic [3:0] rd0, rd1, maddr, mdata, mem_rd;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   mem_1rw_arbiter #(.WIDTH_P(4), .ADDR_P(4)) dut (
      .clk_i(clk), .reset_i(rst),
      .p0_v_i(v0), .p0_w_i(w0), .p0_lock_i(l0), .p0_addr_i(a0), .p0_data_i(d0),
      .p0_ready_o(rdy0), .p0_rvalid_o(rv0), .p0_rdata_o(rd0),
      .p1_v_i(v1), .p1_w_i(w1), .p1_lock_i(l1), .p1_addr_i(a1), .p1_data_i(d1),
      .p1_ready_o(rdy1), .p1_rvalid_o(rv1), .p1_rdata_o(rd1),
      .mem_v_o(mv), .mem_w_o(mw), .mem_addr_o(maddr), .mem_data_o(mdata),
      .mem_data_i(mem_rd)
   );

   always #5 clk = ~clk;

   // Memory behind the arbiter.
   logic [3:0] mem [16];
   always @(posedge clk) begin
      if (mv) begin
         if (mw) mem[maddr] <= mdata;
         else    mem_rd     <= mem[maddr];
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         m_last = 1;     // last granted port
   int         m_owner = -1;   // port holding a lock, -1 = none
   bit         m_pend [2];
   logic [3:0] m_pdata [2];
   logic [3:0] m_mem [16];

   always @(negedge clk) begin
      int g;
      logic       vv [2];
      logic       ww [2];
      logic       ll [2];
      logic [3:0] aa [2];
      logic [3:0] dd [2];
      vv[0] = v0; vv[1] = v1; ww[0] = w0; ww[1] = w1;
      ll[0] = l0; ll[1] = l1; aa[0] = a0; aa[1] = a1;
      dd[0] = d0; dd[1] = d1;
      g = -1;
      if (rst) begin
         m_pend[0] = 0;
         m_pend[1] = 0;
      end else if (m_owner >= 0) begin
         if (vv[m_owner]) g = m_owner;
      end else if (vv[0] && vv[1]) begin
         g = 1 - m_last;
      end else if (vv[0]) begin
         g = 0;
      end else if (vv[1]) begin
         g = 1;
      end
      if (chk_en) begin
         chk("p0_ready", rdy0, g == 0);
         chk("p1_ready", rdy1, g == 1);
         chk("mem_v", mv, g >= 0);
         chk("mem_w", mw, (g >= 0) ? ww[g] : 0);
         chk("mem_addr", maddr, (g >= 0) ? aa[g] : 0);
         chk("mem_data", mdata, (g >= 0) ? dd[g] : 0);
         chk("p0_rvalid", rv0, m_pend[0]);
         chk("p1_rvalid", rv1, m_pend[1]);
         chk("p0_rdata", rd0, m_pend[0] ? m_pdata[0] : 0);
         chk("p1_rdata", rd1, m_pend[1] ? m_pdata[1] : 0);
      end
      // advance to the state after the coming posedge
      if (rst) begin
         m_last  = 1;
         m_owner = -1;
         m_pend[0] = 0;
         m_pend[1] = 0;
      end else begin
         m_pend[0] = 0;
         m_pend[1] = 0;
         if (g >= 0) begin
            m_last = g;
            if (ww[g]) begin
               m_mem[aa[g]] = dd[g];
            end else begin
               m_pend[g]  = 1;
               m_pdata[g] = m_mem[aa[g]];
            end
`ifdef MEM_1RW_ARBITER_LOCK_EN
            m_owner = ll[g] ? g : -1;
`endif
         end
      end
   end

   // One cycle: apply inputs after posedge, return just after the negedge.
   task automatic drv(input logic r,
                      input logic iv0, input logic iw0, input logic il0,
                      input logic [3:0] ia0, input logic [3:0] id0,
                      input logic iv1, input logic iw1, input logic il1,
                      input logic [3:0] ia1, input logic [3:0] id1);
      @(posedge clk);
      #1;
      rst = r;
      v0 = iv0; w0 = iw0; l0 = il0; a0 = ia0; d0 = id0;
      v1 = iv1; w1 = iw1; l1 = il1; a1 = ia1; d1 = id1;
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      drv(0, 0,0,0,4'h0,4'h0, 0,0,0,4'h0,4'h0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem[i]   = 4'(i * 7 + 1);
         m_mem[i] = 4'(i * 7 + 1);
      end
      mem_rd = 4'h0;
      m_pend[0] = 0; m_pend[1] = 0;
      m_pdata[0] = 0; m_pdata[1] = 0;
      @(posedge clk);
      @(posedge clk);
      chk_en = 1;
      drv(1, 1,0,0,4'h3,4'h0, 1,0,0,4'h5,4'h0);
      chk("reset_ready0", rdy0, 0);
      chk("reset_mem_v", mv, 0);

      // Post-reset contention, reads of addr 3 and 5.
      drv(0, 1,0,0,4'h3,4'h0, 1,0,0,4'h5,4'h0);
      chk("c0_p0_ready", rdy0, 1);
      chk("c0_p1_ready", rdy1, 0);
      drv(0, 0,0,0,4'h0,4'h0, 1,0,0,4'h5,4'h0);
      chk("c1_p1_ready", rdy1, 1);
      chk("c1_p0_rvalid", rv0, 1);
      chk("c1_p0_rdata", rd0, 4'h6);
      idle();
      chk("c2_p1_rvalid", rv1, 1);
      chk("c2_p1_rdata", rd1, 4'h4);

      // Write then read same address.
      drv(0, 1,1,0,4'h7,4'hA, 0,0,0,4'h0,4'h0);
      chk("wr_mem_w", mw, 1);
      drv(0, 0,0,0,4'h0,4'h0, 1,0,0,4'h7,4'h0);
      chk("rd_mem_w", mw, 0);
      chk("rd_mem_addr", maddr, 7);
      idle();
      chk("wr_rd_p1_rdata", rd1, 4'hA);

      // Continuous contention for six cycles.
      for (int i = 0; i < 6; i++) begin
         drv(0, 1,0,0,4'(i),4'h0, 1,0,0,4'(i+8),4'h0);
         chk("alt_p0_ready", rdy0, (i % 2) == 0);
         chk("alt_p1_ready", rdy1, (i % 2) == 1);
         chk("alt_mem_v", mv, 1);
      end
      idle();

      // Lock: p1 locks, then idles two cycles while p0 waits.
      drv(0, 0,0,0,4'h0,4'h0, 1,0,1,4'h2,4'h0);
      chk("lk_p1_ready", rdy1, 1);
      drv(0, 1,0,0,4'h1,4'h0, 0,0,0,4'h0,4'h0);
`ifdef MEM_1RW_ARBITER_LOCK_EN
      chk("lk_idle1_p0_ready", rdy0, 0);
      drv(0, 1,0,0,4'h1,4'h0, 0,0,0,4'h0,4'h0);
      chk("lk_idle2_p0_ready", rdy0, 0);
      drv(0, 1,0,0,4'h1,4'h0, 1,0,0,4'h2,4'h0);
      chk("lk_unlock_p1_ready", rdy1, 1);
      drv(0, 1,0,0,4'h1,4'h0, 0,0,0,4'h0,4'h0);
      chk("lk_after_p0_ready", rdy0, 1);
`else
      chk("nolk_idle1_p0_ready", rdy0, 1);
`endif
      idle();

      // Reset mid-operation, with a lock request outstanding.
      drv(0, 0,0,0,4'h0,4'h0, 1,0,1,4'h4,4'h0);
      drv(1, 1,0,0,4'h1,4'h0, 1,0,0,4'h1,4'h0);
      chk("rst_p1_rvalid", rv1, 0);
      chk("rst_p0_ready", rdy0, 0);
      chk("rst_mem_v", mv, 0);
      drv(0, 1,0,0,4'h1,4'h0, 1,0,0,4'h1,4'h0);
      chk("rel_p0_ready", rdy0, 1);
      chk("rel_p1_rvalid", rv1, 0);
      idle();
      chk("rel_p0_rvalid", rv0, 1);

      // Random traffic checked by the model alone.
      for (int i = 0; i < 3000; i++) begin
         drv($urandom_range(99) == 0,
             1'($urandom), 1'($urandom), $urandom_range(3) == 0,
             4'($urandom), 4'($urandom),
             1'($urandom), 1'($urandom), $urandom_range(3) == 0,
             4'($urandom), 4'($urandom));
      end
      idle();
      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
